// File: rtl/ntsc_timing_gen.sv
// NTSC composite timing generator: free-running line/frame counters, active
// region decode, composite sync with broad vsync pulses, and a 4-bit DAC code
// registered one clock behind the counter state.
module ntsc_timing_gen #(
   parameter int unsigned H_TOTAL   = 1016,
   parameter int unsigned H_SYNC    = 75,
   parameter int unsigned H_BP      = 90,
   parameter int unsigned H_ACTIVE  = 800,
   parameter int unsigned V_TOTAL   = 262,
   parameter int unsigned V_SYNC    = 3,
   parameter int unsigned V_BP      = 16,
   parameter int unsigned V_ACTIVE  = 240,
   parameter logic [3:0]  SYNC_LVL  = 4'd0,
   parameter logic [3:0]  BLANK_LVL = 4'd4,
   parameter logic [3:0]  BLACK_LVL = 4'd5
) (
   input  logic       clk,
   input  logic       NRST,
   input  logic [3:0] pix_luma,
   output logic [3:0] vdac,
   output logic       sync_n,
   output logic       blank,
   output logic       pix_active,
   output logic [9:0] pix_x,
   output logic [7:0] pix_y,
   output logic       frame_start
);

   localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
   localparam logic [9:0] H_BROAD_END = 10'(H_TOTAL - H_SYNC);
   localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [8:0] V_LAST      = 9'(V_TOTAL - 1);
   localparam logic [8:0] V_SYNC_END  = 9'(V_SYNC);
   localparam logic [8:0] V_ACT_START = 9'(V_SYNC + V_BP);
   localparam logic [8:0] V_ACT_END   = 9'(V_SYNC + V_BP + V_ACTIVE);

   logic [9:0] hcount_q, hcount_d;
   logic [8:0] vcount_q, vcount_d;
   logic [3:0] vdac_q, vdac_d;
   logic       sync_n_q, sync_n_d;
   logic       blank_q, blank_d;

   logic       h_act;
   logic       v_act;
   logic       vsync_line;
   logic [3:0] luma_clamped;

   // Next counter state: hcount wraps each line, vcount advances on that wrap.
   always_comb begin
      hcount_d = hcount_q + 10'd1;
      vcount_d = vcount_q;
      if (hcount_q == H_LAST) begin
         hcount_d = '0;
         if (vcount_q == V_LAST) begin
            vcount_d = '0;
         end else begin
            vcount_d = vcount_q + 9'd1;
         end
      end
   end

   // Region decode and pixel coordinates, combinational from the counters.
   always_comb begin
      h_act       = (hcount_q >= H_ACT_START) && (hcount_q < H_ACT_END);
      v_act       = (vcount_q >= V_ACT_START) && (vcount_q < V_ACT_END);
      vsync_line  = (vcount_q < V_SYNC_END);
      pix_active  = h_act && v_act;
      pix_x       = '0;
      pix_y       = '0;
      if (pix_active) begin
         pix_x = hcount_q - H_ACT_START;
         pix_y = 8'(vcount_q - V_ACT_START);
      end
      frame_start = (hcount_q == '0) && (vcount_q == '0);
   end

   // Next DAC-side values from the current counter state; sync has priority
   // over picture, and luma is clamped up to black inside the active region.
   always_comb begin
      if (vsync_line) begin
         sync_n_d = (hcount_q >= H_BROAD_END);
      end else begin
         sync_n_d = (hcount_q >= H_SYNC_END);
      end
      luma_clamped = (pix_luma < BLACK_LVL) ? BLACK_LVL : pix_luma;
      if (!sync_n_d) begin
         vdac_d = SYNC_LVL;
      end else if (pix_active) begin
         vdac_d = luma_clamped;
      end else begin
         vdac_d = BLANK_LVL;
      end
      blank_d = ~pix_active;
   end

   // Line and frame counters.
   always_ff @(posedge clk or negedge NRST) begin
      if (!NRST) begin
         hcount_q <= '0;
         vcount_q <= '0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
      end
   end

   // DAC output registers, one clock behind the counter state.
   always_ff @(posedge clk or negedge NRST) begin
      if (!NRST) begin
         vdac_q   <= BLANK_LVL;
         sync_n_q <= 1'b1;
         blank_q  <= 1'b1;
      end else begin
         vdac_q   <= vdac_d;
         sync_n_q <= sync_n_d;
         blank_q  <= blank_d;
      end
   end

   assign vdac   = vdac_q;
   assign sync_n = sync_n_q;
   assign blank  = blank_q;

endmodule

// File: tb/tb_ntsc_timing_gen.sv
// Randomized check of ntsc_timing_gen against an arithmetic reference model.
// A scaled-down instance covers whole frames; a default-size instance covers
// the first line after reset with the real timing numbers.
module tb_ntsc_timing_gen;

   // scaled-down timing for the small instance
   localparam int unsigned S_HT = 40, S_HS = 4, S_HBP = 5, S_HACT = 24;
   localparam int unsigned S_VT = 20, S_VS = 2, S_VBP = 3, S_VACT = 12;
   localparam int unsigned S_FRAME = S_HT * S_VT;
   localparam int unsigned S_H0 = S_HS + S_HBP;
   localparam int unsigned S_V0 = S_VS + S_VBP;
   // default timing
   localparam int unsigned D_HT = 1016, D_HS = 75, D_HBP = 90, D_HACT = 800;
   localparam int unsigned D_VT = 262, D_VS = 3, D_VBP = 16, D_VACT = 240;

   typedef struct packed {
      logic       act;
      logic [9:0] px;
      logic [7:0] py;
      logic       fs;
      logic       sn;
      logic [3:0] vd;
      logic       bl;
   } exp_t;

   logic       clk;
   logic       NRST_s, NRST_d;
   logic [3:0] luma_s, luma_d;
   logic [3:0] vdac_s, vdac_d;
   logic       sync_n_s, sync_n_d, blank_s, blank_d, act_s, act_d, fs_s, fs_d;
   logic [9:0] px_s, px_d;
   logic [7:0] py_s, py_d;

   int unsigned n_s, n_d;     // clock edges since reset release
   logic [3:0]  lp_s, lp_d;   // luma presented at the most recent edge
   int          checks, passes;
   exp_t        e, r;

   ntsc_timing_gen #(
      .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_BP(S_HBP), .H_ACTIVE(S_HACT),
      .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_BP(S_VBP), .V_ACTIVE(S_VACT)
   ) dut_s (
      .clk(clk), .NRST(NRST_s), .pix_luma(luma_s), .vdac(vdac_s),
      .sync_n(sync_n_s), .blank(blank_s), .pix_active(act_s),
      .pix_x(px_s), .pix_y(py_s), .frame_start(fs_s)
   );

   ntsc_timing_gen dut_d (
      .clk(clk), .NRST(NRST_d), .pix_luma(luma_d), .vdac(vdac_d),
      .sync_n(sync_n_d), .blank(blank_d), .pix_active(act_d),
      .pix_x(px_d), .pix_y(py_d), .frame_start(fs_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs for the counter state reached idx clocks after reset.
   function automatic exp_t model(input int unsigned ht, hs, hbp, hact,
                                  input int unsigned vt, vs, vbp, vact,
                                  input int unsigned idx, input logic [3:0] luma);
      exp_t m;
      int unsigned h, v, h0, v0;
      h = idx % ht;
      v = (idx / ht) % vt;
      h0 = hs + hbp;
      v0 = vs + vbp;
      m.act = (h >= h0) && (h < h0 + hact) && (v >= v0) && (v < v0 + vact);
      m.px  = m.act ? 10'(h - h0) : 10'd0;
      m.py  = m.act ? 8'(v - v0) : 8'd0;
      m.fs  = (h == 0) && (v == 0);
      m.sn  = (v < vs) ? (h >= ht - hs) : (h >= hs);
      if (!m.sn) m.vd = 4'd0;
      else if (m.act) m.vd = (luma < 4'd5) ? 4'd5 : luma;
      else m.vd = 4'd4;
      m.bl  = !m.act;
      return m;
   endfunction

   function automatic exp_t ms(input int unsigned idx, input logic [3:0] luma);
      return model(S_HT, S_HS, S_HBP, S_HACT, S_VT, S_VS, S_VBP, S_VACT, idx, luma);
   endfunction

   function automatic exp_t md(input int unsigned idx, input logic [3:0] luma);
      return model(D_HT, D_HS, D_HBP, D_HACT, D_VT, D_VS, D_VBP, D_VACT, idx, luma);
   endfunction

   // Advance one clock; outputs are then stable 1 time unit after the edge.
   task automatic tick();
      lp_s = luma_s;
      lp_d = luma_d;
      if (NRST_s) n_s++;
      if (NRST_d) n_d++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({vdac_s, sync_n_s, blank_s} !== {4'd4, 1'b1, 1'b1}) begin
         $display("FAIL reset_regs_s actual=%h required=%h", {vdac_s, sync_n_s, blank_s}, {4'd4, 1'b1, 1'b1});
      end else passes++;
      checks++;
      if ({act_s, px_s, py_s, fs_s} !== {1'b0, 10'd0, 8'd0, 1'b1}) begin
         $display("FAIL reset_comb_s actual=%h required=%h", {act_s, px_s, py_s, fs_s}, {1'b0, 10'd0, 8'd0, 1'b1});
      end else passes++;
      checks++;
      if ({vdac_d, sync_n_d, blank_d, fs_d} !== {4'd4, 1'b1, 1'b1, 1'b1}) begin
         $display("FAIL reset_d actual=%h required=%h", {vdac_d, sync_n_d, blank_d, fs_d}, {4'd4, 1'b1, 1'b1, 1'b1});
      end else passes++;
      NRST_s = 1'b1;
      n_s = 0;
      #1;
      checks++;
      if ({vdac_s, sync_n_s, blank_s} !== {4'd4, 1'b1, 1'b1}) begin
         $display("FAIL release_no_edge actual=%h required=%h", {vdac_s, sync_n_s, blank_s}, {4'd4, 1'b1, 1'b1});
      end else passes++;
   endtask

   task automatic test_first_edge();
      luma_s = 4'($urandom_range(15, 0));
      tick();
      checks++;
      if ({vdac_s, sync_n_s, blank_s, fs_s} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
         $display("FAIL first_edge actual=%h required=%h", {vdac_s, sync_n_s, blank_s, fs_s}, {4'd0, 1'b0, 1'b1, 1'b0});
      end else passes++;
   endtask

   task automatic test_frame_random();
      int fs_count;
      fs_count = 0;
      for (int i = 0; i < 2 * S_FRAME; i++) begin
         luma_s = 4'($urandom_range(15, 0));
         tick();
         e = ms(n_s, 4'd0);
         r = ms(n_s - 1, lp_s);
         if (fs_s === 1'b1) fs_count++;
         checks++;
         if ({vdac_s, sync_n_s, blank_s} !== {r.vd, r.sn, r.bl}) begin
            $display("FAIL frame_regs n=%0d actual=%h required=%h", n_s, {vdac_s, sync_n_s, blank_s}, {r.vd, r.sn, r.bl});
         end else passes++;
         checks++;
         if ({act_s, px_s, py_s, fs_s} !== {e.act, e.px, e.py, e.fs}) begin
            $display("FAIL frame_comb n=%0d actual=%h required=%h", n_s, {act_s, px_s, py_s, fs_s}, {e.act, e.px, e.py, e.fs});
         end else passes++;
      end
      checks++;
      if (fs_count != 2) begin
         $display("FAIL frame_start_count actual=%0d required=2", fs_count);
      end else passes++;
   endtask

   task automatic test_active_corners();
      int unsigned target;
      // first active pixel of the first active line, luma below black
      target = S_V0 * S_HT + S_H0;
      for (int k = 0; k < S_FRAME && (n_s % S_FRAME) != target; k++) begin
         luma_s = 4'($urandom_range(15, 0));
         tick();
      end
      checks++;
      if ({act_s, px_s, py_s} !== {1'b1, 10'd0, 8'd0}) begin
         $display("FAIL first_pixel actual=%h required=%h", {act_s, px_s, py_s}, {1'b1, 10'd0, 8'd0});
      end else passes++;
      for (int i = 0; i < S_HACT; i++) begin
         luma_s = 4'd2;
         tick();
         checks++;
         if ({vdac_s, blank_s} !== {4'd5, 1'b0}) begin
            $display("FAIL clamp_black i=%0d actual=%h required=%h", i, {vdac_s, blank_s}, {4'd5, 1'b0});
         end else passes++;
      end
      luma_s = 4'd2;
      tick();
      checks++;
      if ({vdac_s, blank_s} !== {4'd4, 1'b1}) begin
         $display("FAIL after_active actual=%h required=%h", {vdac_s, blank_s}, {4'd4, 1'b1});
      end else passes++;
      // last active pixel of the last active line, full-scale luma
      target = (S_V0 + S_VACT - 1) * S_HT + S_H0 + S_HACT - 1;
      for (int k = 0; k < S_FRAME && (n_s % S_FRAME) != target; k++) begin
         luma_s = 4'($urandom_range(15, 0));
         tick();
      end
      checks++;
      if ({act_s, px_s, py_s} !== {1'b1, 10'(S_HACT - 1), 8'(S_VACT - 1)}) begin
         $display("FAIL last_pixel actual=%h required=%h", {act_s, px_s, py_s}, {1'b1, 10'(S_HACT - 1), 8'(S_VACT - 1)});
      end else passes++;
      luma_s = 4'd15;
      tick();
      checks++;
      if ({vdac_s, blank_s, act_s, px_s, py_s} !== {4'd15, 1'b0, 1'b0, 10'd0, 8'd0}) begin
         $display("FAIL luma_15 actual=%h required=%h", {vdac_s, blank_s, act_s, px_s, py_s}, {4'd15, 1'b0, 1'b0, 10'd0, 8'd0});
      end else passes++;
      luma_s = 4'd15;
      tick();
      checks++;
      if ({vdac_s, blank_s} !== {4'd4, 1'b1}) begin
         $display("FAIL luma_ignored actual=%h required=%h", {vdac_s, blank_s}, {4'd4, 1'b1});
      end else passes++;
   endtask

   task automatic test_async_reset();
      int unsigned target;
      target = 10 * S_HT + 20;
      for (int k = 0; k < S_FRAME && (n_s % S_FRAME) != target; k++) begin
         luma_s = 4'($urandom_range(15, 0));
         tick();
      end
      #2 NRST_s = 1'b0;
      #1;
      checks++;
      if ({vdac_s, sync_n_s, blank_s, act_s, fs_s} !== {4'd4, 1'b1, 1'b1, 1'b0, 1'b1}) begin
         $display("FAIL async_reset actual=%h required=%h", {vdac_s, sync_n_s, blank_s, act_s, fs_s}, {4'd4, 1'b1, 1'b1, 1'b0, 1'b1});
      end else passes++;
      tick();
      tick();
      NRST_s = 1'b1;
      n_s = 0;
      for (int i = 0; i < 2 * S_HT; i++) begin
         luma_s = 4'($urandom_range(15, 0));
         tick();
         e = ms(n_s, 4'd0);
         r = ms(n_s - 1, lp_s);
         checks++;
         if ({vdac_s, sync_n_s, blank_s, act_s, px_s, py_s, fs_s} !== {r.vd, r.sn, r.bl, e.act, e.px, e.py, e.fs}) begin
            $display("FAIL restart n=%0d actual=%h required=%h", n_s, {vdac_s, sync_n_s, blank_s, act_s, px_s, py_s, fs_s}, {r.vd, r.sn, r.bl, e.act, e.px, e.py, e.fs});
         end else passes++;
      end
   endtask

   task automatic test_default_line();
      int low_count;
      low_count = 0;
      NRST_d = 1'b1;
      n_d = 0;
      for (int i = 0; i < D_HT + 8; i++) begin
         luma_d = 4'($urandom_range(15, 0));
         tick();
         e = md(n_d, 4'd0);
         r = md(n_d - 1, lp_d);
         if (i < D_HT && sync_n_d === 1'b0) low_count++;
         checks++;
         if ({vdac_d, sync_n_d, blank_d, act_d, px_d, py_d, fs_d} !== {r.vd, r.sn, r.bl, e.act, e.px, e.py, e.fs}) begin
            $display("FAIL default_line n=%0d actual=%h required=%h", n_d, {vdac_d, sync_n_d, blank_d, act_d, px_d, py_d, fs_d}, {r.vd, r.sn, r.bl, e.act, e.px, e.py, e.fs});
         end else passes++;
      end
      // line 0 is a vsync line: broad pulse low for H_TOTAL-H_SYNC clocks
      checks++;
      if (low_count != int'(D_HT - D_HS)) begin
         $display("FAIL broad_pulse_len actual=%0d required=%0d", low_count, D_HT - D_HS);
      end else passes++;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      n_s = 0;
      n_d = 0;
      luma_s = 4'd0;
      luma_d = 4'd0;
      lp_s = 4'd0;
      lp_d = 4'd0;
      NRST_s = 1'b1;
      NRST_d = 1'b1;
      #2;
      NRST_s = 1'b0;
      NRST_d = 1'b0;
      test_reset();
      test_first_edge();
      test_frame_random();
      test_active_corners();
      test_async_reset();
      test_default_line();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
